mips_boot_loader: RTL and testbench
===================================

// Module: mips_boot_loader
// PURPOSE
//   Upstream loader for the multi-cycle MIPS core. Receives a program image over a
//   byte-wide valid/ready stream and writes it word by word into the unified
//   instruction/data memory. Holds the core in reset until the image is complete
//   and its checksum has been verified, then releases it.
// PARAMETERS
//   MAX_WORDS  256          largest accepted image, in 32-bit words (1..65535)
//   BASE_ADDR  32'h0000_0000 byte address of the first word written; word-aligned
// PORTS
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   in_data     in   8   stream byte
//   in_valid    in   1   in_data valid
//   in_ready    out  1   loader accepts a byte; transfer = in_valid & in_ready
//   reload      in   1   1-cycle pulse: abort or finish, then restart at LEN_HI
//   mem_we      out  1   memory write strobe, 1 cycle per word
//   mem_addr    out  32  byte address of the write
//   mem_wdata   out  32  write data
//   core_rst_n  out  1   active-low reset to the MIPS core
//   done        out  1   image loaded and verified (sticky)
//   error       out  1   bad length or checksum mismatch (sticky)
// BEHAVIOUR
//   Reset: state LEN_HI; mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0,
//     done=0, error=0. Byte lane, word and checksum registers cleared.
//   Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), 4*N payload bytes,
//     then 1 checksum byte = XOR of all payload bytes (length bytes excluded).
//   in_ready = 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 in RUN, ERROR. Combinational
//     from state only; in_valid while in_ready=0 is ignored.
//   FSM transitions (all on an accepted byte unless noted):
//     LEN_HI -> LEN_LO.
//     LEN_LO -> DATA if 1 <= N <= MAX_WORDS, else ERROR.
//     DATA   -> stays until 4*N bytes accepted, then -> CSUM.
//     CSUM   -> RUN if byte == running XOR, else ERROR.
//     RUN, ERROR: remain until reload.
//     reload in any state -> LEN_HI next cycle, core_rst_n=0, done=0, error=0,
//       counters cleared; takes priority over a byte accepted in the same cycle.
//   Word assembly: first payload byte of each word -> bits [31:24], fourth -> [7:0].
//   Write: the cycle after the 4th byte of word k is accepted, mem_we=1,
//     mem_wdata = assembled word, mem_addr = BASE_ADDR + 4*k (k from 0, 32-bit
//     wrap). mem_we is a single-cycle pulse; mem_addr/mem_wdata hold between writes.
//     No backpressure: bytes may arrive every cycle (one write per 4 cycles max).
//   Release: cycle after the matching checksum byte is accepted, core_rst_n=1 and
//     done=1 together; the last mem_we precedes this by >= 1 cycle.
//   Error: error=1 the cycle after the offending byte; core_rst_n stays 0; words
//     already written are left in memory.
//   Async reset mid-frame: immediate return to reset values; partial image in
//     memory is not cleared; core held in reset.
//   All outputs registered except in_ready.
// TESTING
//   1. Frame 00 01 | 12 34 56 78 | 08 -> one mem_we, addr 0x0, data 0x12345678;
//      done=1, core_rst_n=1 one cycle after checksum byte; in_ready=0 afterwards.
//   2. N=3, back-to-back bytes, BASE_ADDR=0x100 -> writes at 0x100,0x104,0x108,
//      correct data, mem_we pulses 4 cycles apart, done after checksum.
//   3. Length 00 00 and length MAX_WORDS+1 -> error=1 after LEN_LO byte, no mem_we,
//      core_rst_n=0.
//   4. Frame 00 01 | DE AD BE EF | 00 (bad checksum, expected 0x22) -> word written,
//      error=1, done=0, core_rst_n=0.
//   5. reload mid-DATA, then a valid frame -> restart at LEN_HI, second frame loads
//      from BASE_ADDR, done=1; reload in RUN -> core_rst_n=0 next cycle.
//   6. rst_n asserted mid-DATA with in_valid held high and random stalls on
//      in_valid -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mips_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed program image over a byte stream,
// writes it word by word into MIPS memory and releases the core once the image verifies.
module mips_boot_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst_n,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
    StCsum,
    StRun,
    StError
  } state_e;

  state_e      state_q;
  logic [15:0] len_q;
  logic [17:0] byte_cnt_q;
  logic [23:0] word_q;
  logic [7:0]  csum_q;

  logic        accept;
  logic [15:0] len_full;
  logic        len_ok;
  logic        last_byte;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo, StData, StCsum: in_ready = 1'b1;
      default:                          in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign len_full  = {len_q[15:8], in_data};
  assign len_ok    = (len_full != 16'd0) && ({16'd0, len_full} <= MAX_WORDS);
  assign last_byte = byte_cnt_q == ({len_q, 2'b00} - 18'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLenHi;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // reload wins over a byte transferred in the same cycle
      if (reload) begin
        state_q    <= StLenHi;
        len_q      <= '0;
        byte_cnt_q <= '0;
        word_q     <= '0;
        csum_q     <= '0;
        core_rst_n <= 1'b0;
        done       <= 1'b0;
        error      <= 1'b0;
      end else if (accept) begin
        unique case (state_q)
          StLenHi: begin
            len_q[15:8] <= in_data;
            state_q     <= StLenLo;
          end
          StLenLo: begin
            len_q <= len_full;
            if (len_ok) begin
              state_q <= StData;
            end else begin
              state_q <= StError;
              error   <= 1'b1;
            end
          end
          StData: begin
            word_q     <= {word_q[15:0], in_data};
            csum_q     <= csum_q ^ in_data;
            byte_cnt_q <= byte_cnt_q + 18'd1;
            if (byte_cnt_q[1:0] == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {word_q, in_data};
              mem_addr  <= BASE_ADDR + {14'd0, byte_cnt_q[17:2], 2'b00};
            end
            if (last_byte) begin
              state_q <= StCsum;
            end
          end
          StCsum: begin
            if (in_data == csum_q) begin
              state_q    <= StRun;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state_q <= StError;
              error   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: two instances (base 0 / max 256, base 0x100 / max 4)
// share one byte stream; writes are logged per instance and compared to hand-computed values.
module tb_mips_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        reload = 1'b0;

  logic        in_ready0, mem_we0, core_rst_n0, done0, error0;
  logic [31:0] mem_addr0, mem_wdata0;
  logic        in_ready1, mem_we1, core_rst_n1, done1, error1;
  logic [31:0] mem_addr1, mem_wdata1;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int          wc1[$];

  always #5 clk = ~clk;

  mips_boot_loader #(
    .MAX_WORDS(256),
    .BASE_ADDR(32'h0000_0000)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .reload    (reload),
    .mem_we    (mem_we0),
    .mem_addr  (mem_addr0),
    .mem_wdata (mem_wdata0),
    .core_rst_n(core_rst_n0),
    .done      (done0),
    .error     (error0)
  );

  mips_boot_loader #(
    .MAX_WORDS(4),
    .BASE_ADDR(32'h0000_0100)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .reload    (reload),
    .mem_we    (mem_we1),
    .mem_addr  (mem_addr1),
    .mem_wdata (mem_wdata1),
    .core_rst_n(core_rst_n1),
    .done      (done1),
    .error     (error1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we0) begin
      wa0.push_back(mem_addr0);
      wd0.push_back(mem_wdata0);
    end
    if (mem_we1) begin
      wa1.push_back(mem_addr1);
      wd1.push_back(mem_wdata1);
      wc1.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_log();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete(); wc1.delete();
  endtask

  // Present one byte for exactly one cycle; returns 1 time unit after the transfer edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload(input logic v, input logic [7:0] b);
    @(negedge clk);
    reload   = 1'b1;
    in_valid = v;
    in_data  = b;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_we", {31'd0, mem_we0}, 32'd0);
    check("rst_addr", mem_addr1, 32'd0);
    check("rst_wdata", mem_wdata0, 32'd0);
    check("rst_core", {31'd0, core_rst_n0}, 32'd0);
    check("rst_done_err", {30'd0, done0, error0}, 32'd0);
    check("rst_ready", {31'd0, in_ready0}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single word frame
    clear_log();
    send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    check("t1_we_pulse", {31'd0, mem_we0}, 32'd1);
    check("t1_done_early", {31'd0, done0}, 32'd0);
    send(8'h08);
    check("t1_we_single", {31'd0, mem_we0}, 32'd0);
    check("t1_done", {31'd0, done0}, 32'd1);
    check("t1_core", {31'd0, core_rst_n0}, 32'd1);
    check("t1_ready", {31'd0, in_ready0}, 32'd0);
    idle();
    check("t1_nwr", wa0.size(), 32'd1);
    check("t1_addr", wa0[0], 32'h0000_0000);
    check("t1_data", wd0[0], 32'h1234_5678);

    // reload in RUN releases nothing and re-asserts core reset next cycle
    pulse_reload(1'b0, 8'h00);
    check("rl_core", {31'd0, core_rst_n0}, 32'd0);
    check("rl_done", {31'd0, done0}, 32'd0);
    check("rl_ready", {31'd0, in_ready0}, 32'd1);

    // 2: three words back to back, checksum 0x0C
    clear_log();
    send(8'h00); send(8'h03);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    send(8'h09); send(8'h0A); send(8'h0B); send(8'h0C);
    send(8'h0C);
    check("t2_done", {31'd0, done1}, 32'd1);
    check("t2_core", {31'd0, core_rst_n1}, 32'd1);
    idle();
    check("t2_nwr", wa1.size(), 32'd3);
    check("t2_a0", wa1[0], 32'h0000_0100);
    check("t2_a1", wa1[1], 32'h0000_0104);
    check("t2_a2", wa1[2], 32'h0000_0108);
    check("t2_d0", wd1[0], 32'h0102_0304);
    check("t2_d1", wd1[1], 32'h0506_0708);
    check("t2_d2", wd1[2], 32'h090A_0B0C);
    check("t2_gap01", wc1[1] - wc1[0], 32'd4);
    check("t2_gap12", wc1[2] - wc1[1], 32'd4);
    check("t2_a2_base0", wa0[2], 32'h0000_0008);

    // 3: bad lengths
    pulse_reload(1'b0, 8'h00);
    clear_log();
    send(8'h00); send(8'h00);
    check("t3_zero_err0", {31'd0, error0}, 32'd1);
    check("t3_zero_err1", {31'd0, error1}, 32'd1);
    check("t3_zero_core", {31'd0, core_rst_n0}, 32'd0);
    check("t3_zero_ready", {31'd0, in_ready0}, 32'd0);
    idle();
    pulse_reload(1'b0, 8'h00);
    send(8'h00); send(8'h05);
    check("t3_max1_err1", {31'd0, error1}, 32'd1);
    check("t3_max1_ok0", {31'd0, error0}, 32'd0);
    idle();
    pulse_reload(1'b0, 8'h00);
    send(8'h00); send(8'h04);
    check("t3_max_ok1", {31'd0, error1}, 32'd0);
    check("t3_max_ready1", {31'd0, in_ready1}, 32'd1);
    idle();
    pulse_reload(1'b0, 8'h00);
    send(8'h01); send(8'h01);
    check("t3_257_err0", {31'd0, error0}, 32'd1);
    idle();
    check("t3_nwr", wa0.size() + wa1.size(), 32'd0);
    pulse_reload(1'b0, 8'h00);

    // 4: bad checksum (correct would be 0x22)
    clear_log();
    send(8'h00); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h00);
    check("t4_err", {31'd0, error0}, 32'd1);
    check("t4_done", {31'd0, done0}, 32'd0);
    check("t4_core", {31'd0, core_rst_n0}, 32'd0);
    idle();
    check("t4_data", wd0[0], 32'hDEAD_BEEF);

    // 5: reload mid-DATA (with a colliding byte), then a good frame
    pulse_reload(1'b0, 8'h00);
    send(8'h00); send(8'h02); send(8'hAA); send(8'hBB); send(8'hCC);
    pulse_reload(1'b1, 8'hFF);
    clear_log();
    send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h08);
    check("t5_done", {31'd0, done1}, 32'd1);
    check("t5_err", {31'd0, error1}, 32'd0);
    idle();
    check("t5_addr", wa1[0], 32'h0000_0100);
    check("t5_data", wd1[0], 32'h1234_5678);

    // 6: async reset mid-DATA with stalling stream
    pulse_reload(1'b0, 8'h00);
    send(8'h00); send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_wdata", mem_wdata0, 32'd0);
    check("t6_addr", mem_addr1, 32'd0);
    check("t6_we", {31'd0, mem_we0}, 32'd0);
    check("t6_flags", {29'd0, core_rst_n0, done0, error0}, 32'd0);
    check("t6_ready", {31'd0, in_ready0}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
